// File: rtl/mux8_rr_sched_pkg.sv
// mux8_rr_sched_pkg: shared definitions for the round-robin mux scheduler.
//   NUM_REQ  number of requesters sharing the mux path
//   SEL_W    width of the mux select / requester index
//   state_e  scheduler states (IDLE=0, GRANT=1, TURN=2)
package mux8_rr_sched_pkg;

   localparam int NUM_REQ = 8;
   localparam int SEL_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_e;

endpackage

// File: rtl/mux8_rr_sched_if.sv
// mux8_rr_sched_if: request/data bundle between the requesting units and
// the scheduler.
//   req[7:0]  level-sensitive request lines          (requesters -> scheduler)
//   din[7:0]  data bit from each requester           (requesters -> scheduler)
//   gnt[7:0]  one-hot grant, zero when idle          (scheduler -> requesters)
//   sel[2:0]  index of current/last grantee          (scheduler -> requesters)
//   busy      a grant is active                      (scheduler -> requesters)
//   dout      routed bit of the grantee, 0 when idle (scheduler -> line)
// Modports: master = requester side, slave = scheduler side.
interface mux8_rr_sched_if;
   import mux8_rr_sched_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] din;
   logic [NUM_REQ-1:0] gnt;
   logic [SEL_W-1:0]   sel;
   logic               busy;
   logic               dout;

   modport master (output req, output din, input gnt, input sel, input busy, input dout);
   modport slave  (input req, input din, output gnt, output sel, output busy, output dout);

endinterface

// File: rtl/mux8.sv
// mux8: plain 8:1 single-bit multiplexer.
//   in0..in7  data inputs
//   sel[2:0]  select
//   out       in<sel>
module mux8 (
   input  logic       in0,
   input  logic       in1,
   input  logic       in2,
   input  logic       in3,
   input  logic       in4,
   input  logic       in5,
   input  logic       in6,
   input  logic       in7,
   input  logic [2:0] sel,
   output logic       out
);

   always_comb begin
      unique case (sel)
         3'd0:    out = in0;
         3'd1:    out = in1;
         3'd2:    out = in2;
         3'd3:    out = in3;
         3'd4:    out = in4;
         3'd5:    out = in5;
         3'd6:    out = in6;
         default: out = in7;
      endcase
   end

endmodule

// File: rtl/mux8_rr_sched_rr_pick8.sv
// rr_pick8: combinational rotating priority search.
//   req[7:0]  request lines
//   ptr[2:0]  highest-priority index; order is ptr, ptr+1, ... ptr+7 (mod 8)
//   found     at least one request is set
//   idx[2:0]  first set request in search order (0 when none)
module rr_pick8
   import mux8_rr_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               found,
   output logic [SEL_W-1:0]   idx
);

   logic [SEL_W-1:0] cand;

   // Walk from the lowest priority to the highest so the last hit,
   // i.e. the one closest to ptr, is what remains in idx.
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch,
      // otherwise the tool infers a latch to hold the old value.
      found = |req;
      idx   = '0;
      cand  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = ptr + SEL_W'(i);
         if (req[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin scheduler sharing one 8:1 bit mux among eight
// requesters. A grant lasts until the grantee drops req or has held it
// HOLD_MAX cycles (HOLD_MAX=0: no limit); on release the grantee becomes
// lowest priority.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux8_rr_sched_if.slave: req/din in, gnt/sel/busy registered out,
//          dout = mux8(din, sel) & busy (combinational)
// Build option: define MUX8_SCHED_TURNAROUND_EN to insert a one-cycle
// idle TURN state after every release.
module mux8_rr_sched
   import mux8_rr_sched_pkg::*;
#(
   parameter int HOLD_MAX = 4,
   parameter int HOLD_W   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   mux8_rr_sched_if.slave  bus
);

   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               busy_q, busy_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

   logic               release_now;
   logic [SEL_W-1:0]   pick_ptr;
   logic               pick_found;
   logic [SEL_W-1:0]   pick_idx;
   logic               mux_out;

   // While granting, search as if ptr had already moved past the grantee so
   // a release can re-grant on the same edge.
   assign pick_ptr = (state_q == ST_GRANT) ? sel_q + SEL_W'(1) : ptr_q;

   rr_pick8 u_pick (
      .req   (bus.req),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign release_now = !bus.req[sel_q] || ((HOLD_MAX != 0) && (hold_cnt_q == HOLD_LIM));

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      sel_d      = sel_q;
      busy_d     = busy_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;

      unique case (state_q)
         ST_GRANT: begin
            if (!release_now) begin
               // With HOLD_MAX=0 the counter just wraps; nothing reads it.
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else begin
               ptr_d = sel_q + SEL_W'(1);
`ifdef MUX8_SCHED_TURNAROUND_EN
               state_d = ST_TURN;
               gnt_d   = '0;
               busy_d  = 1'b0;
`else
               if (pick_found) begin
                  gnt_d      = NUM_REQ'(1) << pick_idx;
                  sel_d      = pick_idx;
                  hold_cnt_d = HOLD_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
                  busy_d  = 1'b0;
               end
`endif
            end
         end
`ifdef MUX8_SCHED_TURNAROUND_EN
         ST_TURN: begin
            if (pick_found) begin
               state_d    = ST_GRANT;
               gnt_d      = NUM_REQ'(1) << pick_idx;
               sel_d      = pick_idx;
               busy_d     = 1'b1;
               hold_cnt_d = HOLD_W'(1);
            end else begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: begin
            // IDLE, and recovery from any unused encoding.
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            if (pick_found) begin
               state_d    = ST_GRANT;
               gnt_d      = NUM_REQ'(1) << pick_idx;
               sel_d      = pick_idx;
               busy_d     = 1'b1;
               hold_cnt_d = HOLD_W'(1);
            end
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         sel_q      <= '0;
         busy_q     <= 1'b0;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   mux8 u_mux (
      .in0 (bus.din[0]),
      .in1 (bus.din[1]),
      .in2 (bus.din[2]),
      .in3 (bus.din[3]),
      .in4 (bus.din[4]),
      .in5 (bus.din[5]),
      .in6 (bus.din[6]),
      .in7 (bus.din[7]),
      .sel (sel_q),
      .out (mux_out)
   );

   assign bus.gnt  = gnt_q;
   assign bus.sel  = sel_q;
   assign bus.busy = busy_q;
   assign bus.dout = mux_out & busy_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb_mux8_rr_sched: directed bench for mux8_rr_sched (default build,
// back-to-back grants). u_dut uses HOLD_MAX=4, u_dut_nl uses HOLD_MAX=0.
module tb_mux8_rr_sched;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mux8_rr_sched_if bus0 ();
   mux8_rr_sched_if bus1 ();

   mux8_rr_sched #(.HOLD_MAX(4), .HOLD_W(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   mux8_rr_sched #(.HOLD_MAX(0), .HOLD_W(4)) u_dut_nl (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      bus0.req = '0;
      bus1.req = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      bus0.req = '0;
      bus0.din = 8'hFF;
      bus1.req = '0;
      bus1.din = 8'hFF;
      #3;
      total++;
      if (bus0.gnt !== 8'h00 || bus0.sel !== 3'd0 || bus0.busy !== 1'b0 || bus0.dout !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: gnt=%h sel=%0d busy=%b dout=%b want 00/0/0/0",
                  bus0.gnt, bus0.sel, bus0.busy, bus0.dout);
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++;
         if (bus0.gnt !== 8'h00 || bus0.sel !== 3'd0 || bus0.busy !== 1'b0 || bus0.dout !== 1'b0) begin
            bad++;
            $display("FAIL idle_c%0d: gnt=%h sel=%0d busy=%b dout=%b want 00/0/0/0",
                     c, bus0.gnt, bus0.sel, bus0.busy, bus0.dout);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      bus0.din = 8'h08;
      bus0.req = 8'h08;
      for (int c = 1; c <= 10; c++) begin
         tick();
         total++;
         if (bus0.gnt !== 8'h08 || bus0.sel !== 3'd3 || bus0.busy !== 1'b1 || bus0.dout !== 1'b1) begin
            bad++;
            $display("FAIL single_c%0d: gnt=%h sel=%0d busy=%b dout=%b want 08/3/1/1",
                     c, bus0.gnt, bus0.sel, bus0.busy, bus0.dout);
         end
      end
      // dout follows din combinationally
      bus0.din = 8'hF7;
      #1;
      total++;
      if (bus0.dout !== 1'b0) begin
         bad++;
         $display("FAIL single_din_low: dout=%b want 0", bus0.dout);
      end
      bus0.req = 8'h00;
      tick();
      total++;
      if (bus0.gnt !== 8'h00 || bus0.sel !== 3'd3 || bus0.busy !== 1'b0 || bus0.dout !== 1'b0) begin
         bad++;
         $display("FAIL single_release: gnt=%h sel=%0d busy=%b dout=%b want 00/3/0/0",
                  bus0.gnt, bus0.sel, bus0.busy, bus0.dout);
      end
   endtask

   task automatic test_rotation();
      logic [2:0] exp_idx;
      logic [7:0] exp_gnt;
      logic [7:0] pattern;
      do_reset();
      pattern  = 8'hA6;
      bus0.din = pattern;
      bus0.req = 8'hFF;
      for (int c = 1; c <= 36; c++) begin
         tick();
         exp_idx = 3'((c - 1) / 4);
         exp_gnt = 8'h01 << exp_idx;
         total++;
         if (bus0.gnt !== exp_gnt || bus0.sel !== exp_idx || bus0.busy !== 1'b1
             || bus0.dout !== pattern[exp_idx]) begin
            bad++;
            $display("FAIL rot_c%0d: gnt=%h sel=%0d busy=%b dout=%b want %h/%0d/1/%b",
                     c, bus0.gnt, bus0.sel, bus0.busy, bus0.dout, exp_gnt, exp_idx, pattern[exp_idx]);
         end
      end
      bus0.req = 8'h00;
      tick();
      total++;
      if (bus0.gnt !== 8'h00 || bus0.busy !== 1'b0) begin
         bad++;
         $display("FAIL rot_idle: gnt=%h busy=%b want 00/0", bus0.gnt, bus0.busy);
      end
   endtask

   task automatic test_handoff();
      do_reset();
      bus0.din = 8'h21;
      bus0.req = 8'h04;
      tick();
      total++;
      if (bus0.gnt !== 8'h04 || bus0.sel !== 3'd2 || bus0.dout !== 1'b0) begin
         bad++;
         $display("FAIL hand_first: gnt=%h sel=%0d dout=%b want 04/2/0", bus0.gnt, bus0.sel, bus0.dout);
      end
      tick();
      // grantee 2 drops while 5 and 0 raise on the same cycle
      bus0.req = 8'h21;
      tick();
      total++;
      if (bus0.gnt !== 8'h20 || bus0.sel !== 3'd5 || bus0.busy !== 1'b1 || bus0.dout !== 1'b1) begin
         bad++;
         $display("FAIL hand_to5: gnt=%h sel=%0d busy=%b dout=%b want 20/5/1/1",
                  bus0.gnt, bus0.sel, bus0.busy, bus0.dout);
      end
      for (int c = 2; c <= 4; c++) begin
         tick();
         total++;
         if (bus0.gnt !== 8'h20) begin
            bad++;
            $display("FAIL hand_hold5_c%0d: gnt=%h want 20", c, bus0.gnt);
         end
      end
      tick();
      total++;
      if (bus0.gnt !== 8'h01 || bus0.sel !== 3'd0 || bus0.busy !== 1'b1) begin
         bad++;
         $display("FAIL hand_to0: gnt=%h sel=%0d busy=%b want 01/0/1", bus0.gnt, bus0.sel, bus0.busy);
      end
      bus0.req = 8'h00;
      tick();
      total++;
      if (bus0.gnt !== 8'h00 || bus0.sel !== 3'd0 || bus0.busy !== 1'b0) begin
         bad++;
         $display("FAIL hand_idle: gnt=%h sel=%0d busy=%b want 00/0/0", bus0.gnt, bus0.sel, bus0.busy);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus0.din = 8'h01;
      bus0.req = 8'h20;
      tick();
      total++;
      if (bus0.gnt !== 8'h20 || bus0.sel !== 3'd5) begin
         bad++;
         $display("FAIL arst_pre: gnt=%h sel=%0d want 20/5", bus0.gnt, bus0.sel);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus0.gnt !== 8'h00 || bus0.busy !== 1'b0 || bus0.sel !== 3'd0 || bus0.dout !== 1'b0) begin
         bad++;
         $display("FAIL arst_immediate: gnt=%h sel=%0d busy=%b dout=%b want 00/0/0/0",
                  bus0.gnt, bus0.sel, bus0.busy, bus0.dout);
      end
      bus0.req = 8'h21;
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if (bus0.gnt !== 8'h01 || bus0.sel !== 3'd0 || bus0.busy !== 1'b1 || bus0.dout !== 1'b1) begin
         bad++;
         $display("FAIL arst_first: gnt=%h sel=%0d busy=%b dout=%b want 01/0/1/1",
                  bus0.gnt, bus0.sel, bus0.busy, bus0.dout);
      end
      bus0.req = 8'h00;
      tick();
   endtask

   task automatic test_no_limit();
      do_reset();
      bus1.din = 8'h02;
      bus1.req = 8'h02;
      for (int c = 1; c <= 20; c++) begin
         // other lines toggling must not disturb the grant
         bus1.req = (c >= 8 && c <= 13) ? 8'hFF : 8'h02;
         tick();
         total++;
         if (bus1.gnt !== 8'h02 || bus1.sel !== 3'd1 || bus1.busy !== 1'b1 || bus1.dout !== 1'b1) begin
            bad++;
            $display("FAIL nolimit_c%0d: gnt=%h sel=%0d busy=%b dout=%b want 02/1/1/1",
                     c, bus1.gnt, bus1.sel, bus1.busy, bus1.dout);
         end
      end
      bus1.req = 8'h00;
      tick();
      total++;
      if (bus1.gnt !== 8'h00 || bus1.sel !== 3'd1 || bus1.busy !== 1'b0 || bus1.dout !== 1'b0) begin
         bad++;
         $display("FAIL nolimit_idle: gnt=%h sel=%0d busy=%b dout=%b want 00/1/0/0",
                  bus1.gnt, bus1.sel, bus1.busy, bus1.dout);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single();
      test_rotation();
      test_handoff();
      test_async_reset();
      test_no_limit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
